frame_downsampler: RTL and testbench
====================================

# frame_downsampler

Parametrised successor to the fixed 2:1 camera-stream downsampler. It sits between the pixel capture front end and the feature-detection pipeline and reduces an 8-bit (or wider) raster by 2^LOG2F in each dimension. It supports two modes: plain decimation, or box-averaging through a one-line accumulator buffer. It tracks the full raster, including blanking, and emits registered pixel, blanking, start-of-frame and end-of-line markers.

## Interface
- DATA_W, 8, pixel width in bits.
- H_ACTIVE, 800, active columns. Must be divisible by F = 2^LOG2F.
- V_ACTIVE, 600, active rows. Must be divisible by F.
- H_TOTAL, 840, total columns including blanking. Must be > H_ACTIVE.
- V_TOTAL, 640, total rows including blanking. Must be > V_ACTIVE.
- LOG2F, 1, downsample exponent, 0..2. F = 1, 2 or 4.
- MODE, 0, 0 = decimate, 1 = box average.
- clock  in  1  rising-edge clock for all state.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  in_data carries an active pixel this cycle.
- in_data  in  DATA_W  input pixel.
- in_sof  in  1  with in_valid, marks this pixel as raster (0,0).
- out_valid  out  1  out_data holds a downsampled pixel.
- out_data  out  DATA_W  downsampled pixel. Forced to 0 when out_valid is low.
- out_blank  out  1  the position just consumed was in blanking.
- out_sof  out  1  high with the first output pixel of a frame.
- out_eol  out  1  high with the last output pixel of each output row.

## Operation
- Position counters: row in 0..V_TOTAL-1, col in 0..H_TOTAL-1.
- Active position: row < V_ACTIVE and col < H_ACTIVE.
- In the active region, col advances only on in_valid. In blanking, col advances every cycle and in_valid is ignored.
- col wraps from H_TOTAL-1 to 0 and increments row. row wraps from V_TOTAL-1 to 0.
- Accepted pixel: active position and in_valid.
- in_sof with in_valid: the pixel is processed as (0,0), and the counters then load (0,1).
- in_sof without in_valid is ignored.
- Decimate (MODE 0): emit in_data for accepted pixels where row%F==0 and col%F==0.
- Average (MODE 1):
  - hsum (DATA_W+LOG2F bits) accumulates F horizontally adjacent pixels. It is cleared at col%F==0.
  - Line buffer: H_ACTIVE/F entries of ACC_W = DATA_W+2*LOG2F bits, indexed col/F.
  - At col%F==F-1 with row%F==0: the entry is overwritten with the completed hsum.
  - At col%F==F-1 with other rows: the completed hsum is added to the entry.
  - At col%F==F-1 with row%F==F-1: emit (entry + hsum + 2^(2*LOG2F-1)) >> 2*LOG2F, which is round-half-up. The entry is not rewritten.
  - With LOG2F=0, average mode degenerates to pass-through and no rounding is applied.
- out_sof: set on the first emitted pixel with output row 0 and output column 0.
- out_eol: set on the emitted pixel with output column H_ACTIVE/F-1.
- Partial blocks left by an in_sof resync are discarded. Row 0 always overwrites line-buffer entries, so stale sums never leak into the new frame.

## Timing
- Every output is a register. All outputs reset to 0.
- Reset also clears row, col and hsum. Line-buffer contents need not be reset.
- Latency: an output appears 1 cycle after the accepted pixel that completes it. That pixel is the block's top-left pixel in decimate mode and its bottom-right pixel in average mode.
- out_valid is a single-cycle pulse per output pixel. There is no back-pressure: the consumer must accept every pulse.
- out_blank is high on the cycle after each blanking position. It is low after active positions, including active positions without in_valid.
- out_sof and out_eol are only ever high together with out_valid.
- With F=1 and a 1×1 active area, out_sof and out_eol coincide on the same output pixel.
- Reset asserted mid-line: outputs clear immediately. The first cycle after release is position (0,0).
- Throughput: one input pixel per cycle sustained. The line-buffer read-modify-write completes within that cycle, or is pipelined with a forwarding path for back-to-back accesses to the same entry.

## Test plan
- Decimate, F=2, default geometry, gapless ramp in_data=col[7:0] -> per output row: out_data 0,2,4,…; 400 pulses; out_eol on pulse 400; 300 rows; out_sof exactly once per frame.
- Average, F=2, pixels alternating 0/255 along each row -> every output is 128 (510/4 rounded up). Constant 100 input -> every output is 100.
- Average, F=4, small geometry (H_ACTIVE=8, V_ACTIVE=8, H_TOTAL=10, V_TOTAL=10), in_data=row*8+col -> outputs 14, 18, 46, 50.
- Random in_valid gaps inside the active region -> output value sequence identical to the gapless run. out_blank high only during cols ≥H_ACTIVE or rows ≥V_ACTIVE. No out_valid there.
- in_sof asserted at row 37, col 100 -> the next outputs restart at output (0,0), out_sof pulses, and no corrupted averages appear.
- reset_n pulsed low mid-line -> all outputs 0 within the same cycle; after release the frame restarts from (0,0) with correct values.

Source files
------------

// File: rtl/frame_downsampler.sv
// Reduces a raster by 2^LOG2F per axis by decimation or box averaging; tracks blanking.
// Registered outputs one cycle after the completing pixel. No backpressure: every out_valid pulse must be taken.
module frame_downsampler #(
  parameter int DATA_W   = 8,
  parameter int H_ACTIVE = 800,
  parameter int V_ACTIVE = 600,
  parameter int H_TOTAL  = 840,
  parameter int V_TOTAL  = 640,
  parameter int LOG2F    = 1,
  parameter int MODE     = 0
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_sof,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_blank,
  output logic              out_sof,
  output logic              out_eol
);

  localparam int F     = 1 << LOG2F;
  localparam int RW    = $clog2(V_TOTAL);
  localparam int CW    = $clog2(H_TOTAL);
  localparam int NB    = H_ACTIVE / F;
  localparam int ACC_W = DATA_W + 2 * LOG2F;
  localparam int HS_W  = DATA_W + LOG2F;

  logic [RW-1:0]     r_row;
  logic [CW-1:0]     r_col;
  logic              w_resync;
  logic [RW-1:0]     w_row;
  logic [CW-1:0]     w_col;
  logic              w_active;
  logic              w_accept;
  logic [RW-1:0]     w_row_lo;
  logic [CW-1:0]     w_col_lo;
  logic [RW-1:0]     w_orow;
  logic [CW-1:0]     w_ocol;
  logic              w_first_blk;
  logic              w_last_col;
  logic              w_emit;
  logic [DATA_W-1:0] w_pix;

  // A start-of-frame pixel is treated as position (0,0) regardless of where the counters are.
  assign w_resync    = in_sof & in_valid;
  assign w_row       = w_resync ? '0 : r_row;
  assign w_col       = w_resync ? '0 : r_col;
  assign w_active    = w_resync | ((r_row < RW'(V_ACTIVE)) && (r_col < CW'(H_ACTIVE)));
  assign w_accept    = in_valid & w_active;
  assign w_row_lo    = w_row & RW'(F - 1);
  assign w_col_lo    = w_col & CW'(F - 1);
  assign w_orow      = w_row >> LOG2F;
  assign w_ocol      = w_col >> LOG2F;
  assign w_first_blk = (w_orow == '0) && (w_ocol == '0);
  assign w_last_col  = (w_ocol == CW'(NB - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_row <= '0;
      r_col <= '0;
    end else if (w_resync) begin
      r_row <= '0;
      r_col <= CW'(1);
    end else if (!w_active || in_valid) begin
      if (r_col == CW'(H_TOTAL - 1)) begin
        r_col <= '0;
        r_row <= (r_row == RW'(V_TOTAL - 1)) ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  generate
    if (MODE == 1 && LOG2F > 0) begin : g_avg
      localparam int IW  = (NB > 1) ? $clog2(NB) : 1;
      localparam int RND = 1 << (2 * LOG2F - 1);

      logic [HS_W-1:0]  r_hsum;
      logic [ACC_W-1:0] r_lbuf [NB];
      logic [IW-1:0]    w_idx;
      logic [HS_W-1:0]  w_hsum;
      logic             w_blk_end;
      logic             w_last_row;
      logic [ACC_W-1:0] w_prev;
      logic [ACC_W-1:0] w_acc;
      logic [ACC_W-1:0] w_total;

      // Row 0 of each block ignores the stored entry, so stale sums never survive a resync.
      assign w_idx      = w_active ? IW'(w_ocol) : '0;
      assign w_hsum     = (w_col_lo == '0) ? HS_W'(in_data) : r_hsum + HS_W'(in_data);
      assign w_blk_end  = (w_col_lo == CW'(F - 1));
      assign w_last_row = (w_row_lo == RW'(F - 1));
      assign w_prev     = (w_row_lo == '0) ? '0 : r_lbuf[w_idx];
      assign w_acc      = w_prev + ACC_W'(w_hsum);
      assign w_total    = w_acc + ACC_W'(RND);
      assign w_emit     = w_accept & w_blk_end & w_last_row;
      assign w_pix      = DATA_W'(w_total >> (2 * LOG2F));

      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          r_hsum <= '0;
        end else if (w_accept) begin
          r_hsum <= w_hsum;
        end
      end

      always_ff @(posedge clock) begin
        if (w_accept && w_blk_end && !w_last_row) begin
          r_lbuf[w_idx] <= w_acc;
        end
      end
    end else begin : g_dec
      // With F=1 averaging is a pass-through, which is exactly decimation.
      assign w_emit = w_accept & (w_row_lo == '0) & (w_col_lo == '0);
      assign w_pix  = in_data;
    end
  endgenerate

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_blank <= 1'b0;
      out_sof   <= 1'b0;
      out_eol   <= 1'b0;
    end else begin
      out_valid <= w_emit;
      out_data  <= w_emit ? w_pix : '0;
      out_blank <= ~w_active;
      out_sof   <= w_emit & w_first_blk;
      out_eol   <= w_emit & w_last_col;
    end
  end

endmodule

// File: tb/tb_frame_downsampler.sv
// Bench for frame_downsampler: four small-geometry instances, table vectors, random frames vs a block-level model.
module tb_frame_downsampler;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset_n;
  logic       in_valid_a [4];
  logic       in_sof_a   [4];
  logic [7:0] in_data_a  [4];
  logic       out_valid_a[4];
  logic [7:0] out_data_a [4];
  logic       out_blank_a[4];
  logic       out_sof_a  [4];
  logic       out_eol_a  [4];

  frame_downsampler #(.DATA_W(8), .H_ACTIVE(16), .V_ACTIVE(8), .H_TOTAL(20), .V_TOTAL(12), .LOG2F(1), .MODE(0)) u_dec (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid_a[0]), .in_data(in_data_a[0]), .in_sof(in_sof_a[0]),
    .out_valid(out_valid_a[0]), .out_data(out_data_a[0]), .out_blank(out_blank_a[0]), .out_sof(out_sof_a[0]), .out_eol(out_eol_a[0]));

  frame_downsampler #(.DATA_W(8), .H_ACTIVE(16), .V_ACTIVE(8), .H_TOTAL(20), .V_TOTAL(12), .LOG2F(1), .MODE(1)) u_avg2 (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid_a[1]), .in_data(in_data_a[1]), .in_sof(in_sof_a[1]),
    .out_valid(out_valid_a[1]), .out_data(out_data_a[1]), .out_blank(out_blank_a[1]), .out_sof(out_sof_a[1]), .out_eol(out_eol_a[1]));

  frame_downsampler #(.DATA_W(8), .H_ACTIVE(8), .V_ACTIVE(8), .H_TOTAL(10), .V_TOTAL(10), .LOG2F(2), .MODE(1)) u_avg4 (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid_a[2]), .in_data(in_data_a[2]), .in_sof(in_sof_a[2]),
    .out_valid(out_valid_a[2]), .out_data(out_data_a[2]), .out_blank(out_blank_a[2]), .out_sof(out_sof_a[2]), .out_eol(out_eol_a[2]));

  frame_downsampler #(.DATA_W(8), .H_ACTIVE(1), .V_ACTIVE(1), .H_TOTAL(3), .V_TOTAL(2), .LOG2F(0), .MODE(1)) u_pass (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid_a[3]), .in_data(in_data_a[3]), .in_sof(in_sof_a[3]),
    .out_valid(out_valid_a[3]), .out_data(out_data_a[3]), .out_blank(out_blank_a[3]), .out_sof(out_sof_a[3]), .out_eol(out_eol_a[3]));

  int ha[4], va[4], ht[4], vt[4], ff[4], md[4];
  int pix[0:15][0:15];
  int got[0:15][0:15];
  int nvec = 0;
  int nmis = 0;

  typedef struct {
    int k;
    int pat;
    int orow;
    int ocol;
    int exp;
  } vec_t;
  vec_t tbl[15];

  function automatic void chk(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nmis++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endfunction

  // Pattern 6 keeps the previous frame's pixels so a gapped rerun can be compared with the gapless one.
  function automatic void fill(input int k, input int pat);
    for (int r = 0; r < va[k]; r++)
      for (int c = 0; c < ha[k]; c++)
        case (pat)
          0: pix[r][c] = c;
          1: pix[r][c] = r * ha[k] + c;
          2: pix[r][c] = (c % 2) ? 255 : 0;
          3: pix[r][c] = 100;
          4: pix[r][c] = $urandom_range(0, 255);
          5: pix[r][c] = 77;
          default: ;
        endcase
  endfunction

  function automatic bit completes(input int k, input int r, input int c);
    if (md[k] == 0) return (r % ff[k] == 0) && (c % ff[k] == 0);
    return (r % ff[k] == ff[k] - 1) && (c % ff[k] == ff[k] - 1);
  endfunction

  function automatic int model(input int k, input int r, input int c);
    int f, sum;
    f = ff[k];
    if (md[k] == 0) return pix[r][c];
    sum = 0;
    for (int i = 0; i < f; i++)
      for (int j = 0; j < f; j++)
        sum += pix[r - f + 1 + i][c - f + 1 + j];
    if (f == 1) return sum;
    return (sum + f * f / 2) / (f * f);
  endfunction

  task automatic check_quiet(input int k, input int blank_exp, input string tag);
    chk($sformatf("k%0d %s blank", k, tag), int'(out_blank_a[k]), blank_exp);
    chk($sformatf("k%0d %s valid", k, tag), int'(out_valid_a[k]), 0);
    chk($sformatf("k%0d %s data", k, tag), int'(out_data_a[k]), 0);
    chk($sformatf("k%0d %s sof", k, tag), int'(out_sof_a[k]), 0);
    chk($sformatf("k%0d %s eol", k, tag), int'(out_eol_a[k]), 0);
  endtask

  // Walks one raster in order; inputs change on negedge, outputs are checked one negedge later.
  task automatic run_frame(input int k, input int pat, input bit use_sof, input bit gaps,
                           input int stop_r, input int stop_c);
    int f, nsof, nout, ng;
    bit stopped, act, ev;
    f = ff[k];
    nsof = 0;
    nout = 0;
    stopped = 0;
    fill(k, pat);
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++)
        got[r][c] = -1;
    for (int r = 0; r < vt[k] && !stopped; r++) begin
      for (int c = 0; c < ht[k] && !stopped; c++) begin
        act = (r < va[k]) && (c < ha[k]);
        if (act) begin
          ng = 0;
          if (gaps && $urandom_range(0, 3) == 0) ng = $urandom_range(1, 3);
          for (int g = 0; g < ng; g++) begin
            in_valid_a[k] = 1'b0;
            in_sof_a[k]   = 1'($urandom_range(0, 1));
            in_data_a[k]  = 8'($urandom);
            @(negedge clock);
            check_quiet(k, 0, $sformatf("gap r%0d c%0d", r, c));
          end
          in_valid_a[k] = 1'b1;
          in_sof_a[k]   = use_sof && (r == 0) && (c == 0);
          in_data_a[k]  = 8'(pix[r][c]);
          @(negedge clock);
          ev = completes(k, r, c);
          chk($sformatf("k%0d r%0d c%0d blank", k, r, c), int'(out_blank_a[k]), 0);
          chk($sformatf("k%0d r%0d c%0d valid", k, r, c), int'(out_valid_a[k]), int'(ev));
          if (ev) begin
            chk($sformatf("k%0d r%0d c%0d data", k, r, c), int'(out_data_a[k]), model(k, r, c));
            chk($sformatf("k%0d r%0d c%0d sof", k, r, c), int'(out_sof_a[k]), int'(r / f == 0 && c / f == 0));
            chk($sformatf("k%0d r%0d c%0d eol", k, r, c), int'(out_eol_a[k]), int'(c / f == ha[k] / f - 1));
            got[r / f][c / f] = int'(out_data_a[k]);
            nout += int'(out_valid_a[k]);
            nsof += int'(out_sof_a[k]);
          end else begin
            chk($sformatf("k%0d r%0d c%0d idle data", k, r, c), int'(out_data_a[k]), 0);
            chk($sformatf("k%0d r%0d c%0d idle sof", k, r, c), int'(out_sof_a[k]), 0);
            chk($sformatf("k%0d r%0d c%0d idle eol", k, r, c), int'(out_eol_a[k]), 0);
          end
          if (r == stop_r && c == stop_c) stopped = 1;
        end else begin
          in_valid_a[k] = 1'($urandom_range(0, 1));
          in_sof_a[k]   = in_valid_a[k] ? 1'b0 : 1'($urandom_range(0, 1));
          in_data_a[k]  = 8'($urandom);
          @(negedge clock);
          check_quiet(k, 1, $sformatf("blank r%0d c%0d", r, c));
        end
      end
    end
    in_valid_a[k] = 1'b0;
    in_sof_a[k]   = 1'b0;
    if (!stopped) begin
      chk($sformatf("k%0d sof count", k), nsof, 1);
      chk($sformatf("k%0d output count", k), nout, (va[k] / f) * (ha[k] / f));
    end
  endtask

  initial begin
    int lastk, lastp;
    ha = '{16, 16, 8, 1};
    va = '{8, 8, 8, 1};
    ht = '{20, 20, 10, 3};
    vt = '{12, 12, 10, 2};
    ff = '{2, 2, 4, 1};
    md = '{0, 1, 1, 1};

    tbl[0]  = '{0, 0, 0, 0, 0};
    tbl[1]  = '{0, 0, 0, 3, 6};
    tbl[2]  = '{0, 0, 0, 7, 14};
    tbl[3]  = '{0, 0, 3, 5, 10};
    tbl[4]  = '{1, 2, 0, 0, 128};
    tbl[5]  = '{1, 2, 3, 7, 128};
    tbl[6]  = '{1, 3, 0, 0, 100};
    tbl[7]  = '{1, 3, 2, 5, 100};
    tbl[8]  = '{2, 1, 0, 0, 14};
    tbl[9]  = '{2, 1, 0, 1, 18};
    tbl[10] = '{2, 1, 1, 0, 46};
    tbl[11] = '{2, 1, 1, 1, 50};
    tbl[12] = '{3, 5, 0, 0, 77};
    tbl[13] = '{1, 3, 3, 7, 100};
    tbl[14] = '{0, 0, 2, 4, 8};

    reset_n = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in_valid_a[k] = 1'b0;
      in_sof_a[k]   = 1'b0;
      in_data_a[k]  = 8'h00;
    end
    repeat (3) @(negedge clock);
    for (int k = 0; k < 4; k++) check_quiet(k, 0, "reset");
    reset_n = 1'b1;

    // Directed vectors: each new (instance, pattern) pair runs one gapless frame, then reads the block.
    lastk = -1;
    lastp = -1;
    for (int i = 0; i < 15; i++) begin
      if (tbl[i].k != lastk || tbl[i].pat != lastp) begin
        run_frame(tbl[i].k, tbl[i].pat, 1'b1, 1'b0, -1, -1);
        lastk = tbl[i].k;
        lastp = tbl[i].pat;
      end
      chk($sformatf("table %0d k%0d out(%0d,%0d)", i, tbl[i].k, tbl[i].orow, tbl[i].ocol),
          got[tbl[i].orow][tbl[i].ocol], tbl[i].exp);
    end

    // Random frames, then the same pixels again with input gaps and a free-running frame wrap.
    for (int k = 0; k < 4; k++) begin
      run_frame(k, 4, 1'b1, 1'b0, -1, -1);
      run_frame(k, 6, 1'b0, 1'b1, -1, -1);
      run_frame(k, 4, 1'b0, 1'b1, -1, -1);
    end

    // Resync mid-frame, leaving a partial horizontal sum and partial line-buffer rows behind.
    run_frame(1, 4, 1'b1, 1'b1, 3, 6);
    run_frame(1, 4, 1'b1, 1'b1, -1, -1);
    run_frame(2, 4, 1'b1, 1'b0, 5, 2);
    run_frame(2, 4, 1'b1, 1'b1, -1, -1);
    run_frame(0, 4, 1'b1, 1'b0, 4, 7);
    run_frame(0, 4, 1'b1, 1'b1, -1, -1);

    // Reset mid-line right as an output pulse is showing.
    run_frame(1, 4, 1'b1, 1'b0, 1, 9);
    #1 reset_n = 1'b0;
    #1;
    check_quiet(1, 0, "async reset");
    @(negedge clock);
    reset_n = 1'b1;
    run_frame(1, 4, 1'b0, 1'b1, -1, -1);
    run_frame(2, 4, 1'b0, 1'b0, -1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
